fir_window_feeder: RTL
======================

Name: fir_window_feeder

Overview:
- Streaming front end for the binary symmetric FIR datapath. It accepts one N-bit binary sample per handshake.
- It keeps a TAPS-deep delay line of the most recent samples and presents the full tap window as the FIR's parallel input array.
- Each window is held stable until the downstream FIR/accumulator stage acknowledges it.
- It is the producer side of the FIR input interface; the FIR is the consumer.

Parameters:
- N, 12, sample width in bits (matches FIR word width).
- TAPS, 19, delay-line depth / window length.
- ZERO_PRIME, 0, 0 = first window only after TAPS real samples; 1 = window valid from first sample with zero-filled history.
- CNT_W, 16, width of window counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  feeder can accept a sample this cycle.
- s_data  in  N  input sample (two's-complement, passed through unmodified).
- flush  in  1  synchronous clear of delay line and fill state.
- win_valid  out  1  win_data holds a complete window.
- win_ready  in  1  consumer accepts current window.
- win_data  out  TAPS*N  window; slice k (bits k*N +: N) = sample k positions old; slice 0 = newest.
- fill_cnt  out  $clog2(TAPS+1)  samples held, saturating at TAPS.
- win_cnt  out  CNT_W  windows accepted by consumer, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - win_valid=0, all win_data slices=0, fill_cnt=0, win_cnt=0.
  - State=EMPTY.
  - s_ready=0 during the reset cycle, 1 afterward.
- Accept: sample accepted when s_valid && s_ready.
- Shift on accept:
  - slice k <= slice k-1 for k=TAPS-1..1; slice 0 <= s_data.
  - fill_cnt increments, saturating at TAPS.
- s_ready = !rst && !flush && (!win_valid || win_ready). This gives a combinational path from win_ready to s_ready, so no bubble when the consumer is always ready.
- Window emission:
  - Set win_valid=1 in the cycle after an accept whose post-shift fill_cnt reaches TAPS (ZERO_PRIME=0), or after any accept (ZERO_PRIME=1).
  - Latency: sample to win_valid is 1 cycle.
  - win_valid clears on win_ready unless a new accept occurs in the same cycle; in that case it stays 1 with the new window.
- Stability: win_data and win_valid must not change while win_valid && !win_ready (no accept is possible then).
- win_cnt increments on each win_valid && win_ready and wraps from 2^CNT_W-1 to 0.
- States:
  - EMPTY: fill_cnt=0. Accept goes to FILLING, or to STREAMING if TAPS=1 or ZERO_PRIME=1.
  - FILLING: 0<fill_cnt<TAPS. Accept that makes fill_cnt=TAPS goes to STREAMING.
  - STREAMING: each accept produces a window. Flush returns to EMPTY.
- Flush:
  - Next cycle: all slices=0, fill_cnt=0, win_valid=0, state=EMPTY; win_cnt retained.
  - Flush dominates a simultaneous s_valid (sample dropped; s_ready=0) and a simultaneous win_ready (window discarded; win_cnt not incremented).
- Reset mid-operation: same as flush, plus win_cnt=0. Reset dominates all other inputs.
- Width rule: no arithmetic on samples; data bits are copied exactly. fill_cnt never exceeds TAPS.

Test Plan:
- Reset, then feed samples 1..19 with win_ready=1 (ZERO_PRIME=0) -> win_valid first high 1 cycle after 19th accept; slice0=19, slice18=1; fill_cnt=19, win_cnt=1 after accept.
- Continue with sample 20 -> next window slice0=20, slice18=2; exactly one window per sample; no bubbles with s_valid=win_ready=1 (19+k samples yield k+1 windows).
- Backpressure: win_ready=0 for 5 cycles with s_valid=1 -> s_ready=0, win_data unchanged 5 cycles; win_ready=1 -> window accepted and next sample accepted same cycle.
- Flush after 10 samples with s_valid=1 same cycle -> that sample dropped, fill_cnt=0, win_valid=0; 19 more samples needed before next window; win_cnt unchanged.
- ZERO_PRIME=1: single sample 0xABC -> win_valid next cycle, slice0=0xABC, slices1..18=0.
- win_cnt wrap (CNT_W=4): 17 accepted windows -> win_cnt=1; rst asserted mid-stream with win_valid=1 -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fir_window_feeder.sv
// Sample delay line feeding the symmetric FIR: shifts in one sample per handshake
// and holds the full TAPS-wide window stable until the consumer takes it.
module fir_window_feeder #(
    parameter int N          = 12,
    parameter int TAPS       = 19,
    parameter int ZERO_PRIME = 0,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [N-1:0]                 s_data,
    input  logic                         flush,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [TAPS*N-1:0]            win_data,
    output logic [$clog2(TAPS+1)-1:0]    fill_cnt,
    output logic [CNT_W-1:0]             win_cnt
);

    localparam int FILL_W = $clog2(TAPS + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(TAPS);

    typedef enum logic [1:0] {EMPTY, FILLING, STREAMING} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N-1:0]        r_taps [TAPS];
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic                r_win_valid;
    logic [CNT_W-1:0]    r_win_cnt;
    logic                w_accept;
    logic                w_emit;
    logic                w_take;

    // Combinational win_ready -> s_ready path lets a held window be replaced in the same cycle.
    assign s_ready    = !rst && !flush && (!r_win_valid || win_ready);
    assign w_accept   = s_valid && s_ready;
    assign w_take     = r_win_valid && win_ready && !flush;
    assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:     w_state_nxt = (TAPS == 1 || ZERO_PRIME != 0) ? STREAMING : FILLING;
            FILLING:   if (w_fill_nxt == FULL) w_state_nxt = STREAMING;
            default:   w_state_nxt = STREAMING;
        endcase
    end

    assign w_emit = w_accept && (w_state_nxt == STREAMING);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_fill      <= '0;
            r_win_valid <= 1'b0;
            r_win_cnt   <= '0;
            for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_fill      <= '0;
            r_win_valid <= 1'b0;
            for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
        end else begin
            if (w_take) r_win_cnt <= r_win_cnt + 1'b1;
            if (w_accept) begin
                for (int k = TAPS - 1; k > 0; k--) r_taps[k] <= r_taps[k-1];
                r_taps[0]   <= s_data;
                r_fill      <= w_fill_nxt;
                r_state     <= w_state_nxt;
                r_win_valid <= w_emit;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_win
        assign win_data[k*N +: N] = r_taps[k];
    end

    assign win_valid = r_win_valid;
    assign fill_cnt  = r_fill;
    assign win_cnt   = r_win_cnt;

endmodule
